// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO between the UART receiver
// and the ALU command interface. It keeps an occupancy count and sticky
// overflow/underflow flags for debug.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              rd,
    output logic [DATA_W-1:0] r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d, full_q, full_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              wr_en, rd_en;

    // A pop only happens with data present. When the FIFO is full, a push is
    // still allowed if a pop frees the head slot in the same cycle.
    always_comb begin
        rd_en = rd & ~empty_q;
        wr_en = wr & (~full_q | rd);
    end

    // Storage and pointer next-state. Pointers wrap naturally modulo the depth.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (wr_en) begin
            mem_d[wp_q] = w_data;
            wp_d        = wp_q + ADDR_W'(1);
        end
        if (rd_en) begin
            rp_d = rp_q + ADDR_W'(1);
        end
    end

    // Occupancy and status flags. They are derived from the next count, so
    // the registered versions always agree with each other.
    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_CNT);
    end

    // Sticky error flags. A new error in the same cycle takes priority over clr_err.
    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (wr & ~wr_en) ovf_d = 1'b1;
        if (rd & empty_q) unf_d = 1'b1;
    end

    // Storage array. It has no reset; reset discards the contents logically.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // The head word falls through with zero latency and reads as zero when the FIFO is empty.
    always_comb begin
        r_data = empty_q ? '0 : mem_q[rp_q];
    end

    assign empty     = empty_q;
    assign full      = full_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] r_data;
    logic          empty, full, overflow, underflow;
    logic [AW:0]   count;

    int n_chk  = 0;
    int n_pass = 0;

    byte unsigned mq[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    uart_rx_fifo #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd),
        .r_data(r_data), .empty(empty), .full(full), .count(count),
        .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".r_data"}, 32'(r_data), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock with the given inputs; the model advances from the pre-edge state.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c, input string tag);
        bit was_empty, was_full, rd_ok, wr_ok;
        wr = w; w_data = d; rd = r; clr_err = c;
        @(posedge clk);
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        rd_ok = r && !was_empty;
        wr_ok = w && (!was_full || r);
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(d);
        if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (w && !wr_ok) m_ovf = 1'b1;
        if (r && was_empty) m_unf = 1'b1;
        #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        check_all(tag);
    endtask

    logic [7:0] seq [4] = '{8'h11, 8'h22, 8'h33, 8'h04};
    logic [7:0] seq2 [4] = '{8'h22, 8'h33, 8'h44, 8'h55};

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all("reset");
        chk("reset.r_data0", 32'(r_data), 32'h0);

        // Fill with four words, then drain them in order.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, seq[i], 1'b0, 1'b0, "fill");
            chk("fill.count", 32'(count), 32'(i + 1));
        end
        chk("fill.full", 32'(full), 32'h1);
        for (int i = 0; i < 4; i++) begin
            chk("drain.head", 32'(r_data), 32'(seq[i]));
            cycle(1'b0, 8'h0, 1'b1, 1'b0, "drain");
            chk("drain.count", 32'(count), 32'(3 - i));
        end
        chk("drain.empty", 32'(empty), 32'h1);

        // Overflow while full, then clear the flag.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h11 * (i + 1), 1'b0, 1'b0, "fill2");
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
        chk("ovf.flag", 32'(overflow), 32'h1);
        chk("ovf.count", 32'(count), 32'h4);
        chk("ovf.head", 32'(r_data), 32'h11);
        cycle(1'b0, 8'h0, 1'b0, 1'b1, "clr");
        chk("clr.flag", 32'(overflow), 32'h0);

        // A simultaneous push and pop while full.
        cycle(1'b1, 8'h55, 1'b1, 1'b0, "fullrw");
        chk("fullrw.head", 32'(r_data), 32'h22);
        chk("fullrw.count", 32'(count), 32'h4);
        chk("fullrw.ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("fullrw.out", 32'(r_data), 32'(seq2[i]));
            cycle(1'b0, 8'h0, 1'b1, 1'b0, "fullrw.pop");
        end

        // A simultaneous push and pop while empty.
        cycle(1'b1, 8'h7E, 1'b1, 1'b0, "emptyrw");
        chk("emptyrw.unf", 32'(underflow), 32'h1);
        chk("emptyrw.empty", 32'(empty), 32'h0);
        chk("emptyrw.count", 32'(count), 32'h1);
        chk("emptyrw.data", 32'(r_data), 32'h7E);
        cycle(1'b0, 8'h0, 1'b1, 1'b1, "emptyrw.pop");

        // Streaming across pointer wrap.
        cycle(1'b1, 8'h00, 1'b0, 1'b0, "stream0");
        for (int i = 1; i < 10; i++) begin
            chk("stream.head", 32'(r_data), 32'(i - 1));
            cycle(1'b1, 8'(i), 1'b1, 1'b0, "stream");
        end
        chk("stream.last", 32'(r_data), 32'h9);
        cycle(1'b0, 8'h0, 1'b1, 1'b0, "stream.end");

        // Asynchronous reset mid-operation with three words held.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, "prerst");
        #2 reset = 1'b1;
        #1;
        chk("arst.empty", 32'(empty), 32'h1);
        chk("arst.count", 32'(count), 32'h0);
        mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        check_all("arst.after");

        // Random traffic. The bias changes between phases so the FIFO visits
        // both the full and the empty boundaries.
        for (int i = 0; i < 600; i++) begin
            int pw, pr;
            pw = ((i / 50) % 2 == 0) ? 75 : 30;
            pr = 100 - pw;
            cycle($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                  $urandom_range(99) < 8, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) receive FIFO between the UART receiver and the ALU command interface.
- Writes one byte per `rx_done_tick` from the receiver.
- Presents the head byte, `empty` and `full` to the interface stage, which consumes bytes with a one-cycle `rd` pulse.
- Adds an occupancy count and sticky overflow/underflow error flags for debug.

Parameters:
- `DATA_W`, 8, width of each stored word in bits.
- `ADDR_W`, 2, address bits; depth = 2**ADDR_W words (default 4).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr`  in  1  write strobe (receiver `rx_done_tick`); one word per cycle high.
- `w_data`  in  DATA_W  word to write, sampled when `wr`=1.
- `rd`  in  1  read/pop strobe from the interface stage; one word per cycle high.
- `r_data`  out  DATA_W  head word (FWFT); valid whenever `empty`=0.
- `empty`  out  1  FIFO holds zero words.
- `full`  out  1  FIFO holds 2**ADDR_W words.
- `count`  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `overflow`  out  1  sticky: a write was attempted while full and not accepted.
- `underflow`  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - write/read pointers = 0, `count` = 0.
  - `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0.
  - Storage array is not reset; contents are discarded logically.
- Storage: 2**ADDR_W x DATA_W register array. Write pointer `wp` and read pointer `rp` are ADDR_W bits each and wrap modulo depth with natural overflow, so there is no special last-entry case.
- `r_data` is combinational from array[`rp`] when `empty`=0, and forced to 0 when `empty`=1.
  - This gives zero-latency FWFT: the downstream stage samples `r_data` in the same cycle it asserts `rd`.
- Write accepted iff `wr`=1 and (`full`=0 or `rd`=1).
  - An accepted write stores `w_data` at array[`wp`] and advances `wp` on the clock edge.
  - A written word is visible on `r_data` the cycle after the write edge, if it is the head.
- Read accepted iff `rd`=1 and `empty`=0. An accepted read advances `rp` on the clock edge.
- Per-cycle cases by (`wr`, `rd`):
  - 00: hold.
  - 10, not full: push; `count`+1; `empty`<=0; `full`<=1 if `count` was depth-1.
  - 10, full: word dropped; `overflow`<=1; pointers unchanged.
  - 01, not empty: pop; `count`-1; `full`<=0; `empty`<=1 if `count` was 1.
  - 01, empty: `underflow`<=1; pointers unchanged.
  - 11, not empty and not full: push and pop; `count`, `empty`, `full` unchanged.
  - 11, full: pop and push both accepted; stays full; no overflow.
  - 11, empty: push only; the read is ignored; `underflow`<=1; `count`<=1; `empty`<=0.
- `empty`, `full` and `count` are registered and consistent with each other every cycle:
  - `empty` == (`count`==0)
  - `full` == (`count`==2**ADDR_W)
- Error flags:
  - `overflow` and `underflow` stay set until `clr_err`=1 or reset.
  - If `clr_err` and a new error occur in the same cycle, the new error wins (flag = 1).
  - `clr_err` does not affect data, pointers or `count`.
- No combinational path from `wr` or `w_data` to `r_data`, `empty` or `full`.
- Only `rd` with `empty`=0 affects pointers combinationally, and only via the next-state logic.

Test Plan:
- Reset then idle -> `empty`=1, `full`=0, `count`=0, `r_data`=0x00, both error flags 0.
- Write 0x11, 0x22, 0x33, 0x04 on consecutive cycles, then pop 4 times -> `r_data` sequence 0x11, 0x22, 0x33, 0x04; `full`=1 after the 4th write; `empty`=1 after the 4th pop; `count` goes 1, 2, 3, 4, 3, 2, 1, 0.
- Fill to full, then write 0xAA with `rd`=0 -> `overflow`=1, `count` stays 4, head still 0x11; then assert `clr_err` -> `overflow`=0.
- Full FIFO with `wr`=1 (0x55) and `rd`=1 in the same cycle -> head becomes 0x22, `count`=4, `full`=1, no `overflow`; 0x55 is read out 4th.
- Empty FIFO with `wr`=1 (0x7E) and `rd`=1 -> `underflow`=1, next cycle `empty`=0, `count`=1, `r_data`=0x7E.
- Wrap-around and reset mid-operation:
  - Write and read 10 words in a streaming pattern (0x00..0x09) -> order preserved across pointer wrap.
  - Assert `reset` asynchronously with `count`=3 -> `empty`=1 and `count`=0 immediately, without waiting for a clock edge.
